// File: rtl/cnn_layer2_fmap_buffer.sv
// Layer-2 feature-map ping-pong buffer.
// Captures the pooled output of the conv/pooling core one channel pass at a
// time into one of two banks. Once a map is complete, that bank is streamed
// to the fully-connected stage in channel-major order. The other bank can be
// filled while the first one is being read out.
//
// Output handshake: a word transfers on every rising edge where
// dout_valid && dout_ready. While dout_valid is high and dout_ready is low,
// dout and dout_last hold their values and dout_valid stays high. dout_valid
// never drops before the word it qualifies has been accepted.
module cnn_layer2_fmap_buffer #(
  parameter int DW     = 24,
  parameter int LINE_W = 4,
  parameter int LINES  = 4,
  parameter int CH     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_valid,
  input  logic [DW-1:0] din,
  input  logic          din_last_in_line,
  input  logic          din_last_pix,
  input  logic [2:0]    phase,
  output logic          buf_full,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [DW-1:0] dout,
  output logic          dout_last,
  output logic          overflow,
  output logic          frame_err,
  output logic          dbg_rd_state,
  output logic [3:0]    dbg_bank_state
);

  localparam int PIX   = LINE_W * LINES;
  localparam int DEPTH = CH * PIX;
  localparam int PW    = $clog2(PIX);
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    B_EMPTY   = 2'd0,
    B_FILLING = 2'd1,
    B_FULL    = 2'd2
  } bank_t;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_t;

  // Both banks live in one array; the top address bit selects the bank.
  logic [DW-1:0] mem [0:2*DEPTH-1];

  bank_t         bank_state [0:1];
  bank_t         bank_nxt   [0:1];
  rd_state_t     rd_state;
  logic          wr_bank;
  logic          wr_bank_nxt;
  logic          rd_bank;
  logic          rd_other;
  logic [PW-1:0] pix_cnt;
  logic [AW-1:0] wr_off;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rd_addr_inc;
  logic          wr_accept;
  logic          wr_close;
  logic          line_end;
  logic          line_err;
  logic          pix_err;
  logic          rd_release;

  // buf_full mirrors "write bank is FULL" exactly, so it doubles as the write gate.
  assign wr_accept   = din_valid && !buf_full;
  assign wr_close    = wr_accept && din_last_pix && (phase == 3'(CH - 1));
  assign wr_off      = AW'(phase) * AW'(PIX) + AW'(pix_cnt);
  assign wr_bank_nxt = wr_close ? ~wr_bank : wr_bank;

  // LINE_W is a power of two, so the low bits of pix_cnt give the column.
  assign line_end = (pix_cnt & PW'(LINE_W - 1)) == PW'(LINE_W - 1);
  assign line_err = wr_accept && (din_last_in_line != line_end);
  assign pix_err  = wr_accept && din_last_pix && (pix_cnt != PW'(PIX - 1));

  assign rd_other    = ~rd_bank;
  assign rd_addr_inc = rd_addr + AW'(1);
  assign rd_release  = (rd_state == RD_STREAM) && dout_valid && dout_ready && dout_last;

  assign dbg_rd_state   = (rd_state == RD_STREAM);
  assign dbg_bank_state = {bank_state[1], bank_state[0]};

  // Next bank states: the writer and the reader never own the same bank, so
  // a close on one bank and a release on the other are both applied.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_nxt[b] = bank_state[b];
      if (wr_accept && (wr_bank == b[0])) begin
        bank_nxt[b] = wr_close ? B_FULL : B_FILLING;
      end
      if (rd_release && (rd_bank == b[0])) begin
        bank_nxt[b] = B_EMPTY;
      end
    end
  end

  // Write-side control: bank states, write pointer, pixel counter, sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_state[0] <= B_EMPTY;
      bank_state[1] <= B_EMPTY;
      wr_bank       <= 1'b0;
      pix_cnt       <= '0;
      buf_full      <= 1'b0;
      overflow      <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      bank_state[0] <= bank_nxt[0];
      bank_state[1] <= bank_nxt[1];
      wr_bank       <= wr_bank_nxt;
      buf_full      <= (bank_nxt[wr_bank_nxt] == B_FULL);
      if (wr_accept) begin
        pix_cnt <= din_last_pix ? '0 : pix_cnt + PW'(1);
      end
      if (din_valid && buf_full) begin
        overflow <= 1'b1;
      end
      if (line_err || pix_err) begin
        frame_err <= 1'b1;
      end
    end
  end

  // Sample storage; contents survive reset and are only overwritten by writes.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[{wr_bank, wr_off}] <= din;
    end
  end

  // Read FSM: streams a FULL bank word by word and chains straight into the
  // other bank when it is already FULL at the final handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state   <= RD_IDLE;
      rd_bank    <= 1'b0;
      rd_addr    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (bank_state[rd_bank] == B_FULL) begin
            rd_state   <= RD_STREAM;
            rd_addr    <= '0;
            dout       <= mem[{rd_bank, AW'(0)}];
            dout_valid <= 1'b1;
            dout_last  <= 1'b0;
          end
        end
        RD_STREAM: begin
          if (dout_ready) begin
            if (dout_last) begin
              rd_bank <= rd_other;
              rd_addr <= '0;
              if (bank_state[rd_other] == B_FULL) begin
                dout       <= mem[{rd_other, AW'(0)}];
                dout_valid <= 1'b1;
                dout_last  <= 1'b0;
              end else begin
                rd_state   <= RD_IDLE;
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
              end
            end else begin
              rd_addr   <= rd_addr_inc;
              dout      <= mem[{rd_bank, rd_addr_inc}];
              dout_last <= (rd_addr_inc == AW'(DEPTH - 1));
            end
          end
        end
        default: begin
          rd_state   <= RD_IDLE;
          dout_valid <= 1'b0;
          dout_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer2_fmap_buffer.sv
// Bench for the layer-2 feature-map ping-pong buffer. The reference model keeps
// two plain word arrays (one per bank) plus a queue of every word the FC stage
// should see, in order, pushed when a map is closed.
module tb_cnn_layer2_fmap_buffer;

  localparam int DW    = 24;
  localparam int PIX   = 16;
  localparam int DEPTH = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          din_valid;
  logic [DW-1:0] din;
  logic          din_last_in_line;
  logic          din_last_pix;
  logic [2:0]    phase;
  logic          buf_full;
  logic          dout_valid;
  logic          dout_ready;
  logic [DW-1:0] dout;
  logic          dout_last;
  logic          overflow;
  logic          frame_err;
  logic          dbg_rd_state;
  logic [3:0]    dbg_bank_state;

  cnn_layer2_fmap_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .din_valid        (din_valid),
    .din              (din),
    .din_last_in_line (din_last_in_line),
    .din_last_pix     (din_last_pix),
    .phase            (phase),
    .buf_full         (buf_full),
    .dout_valid       (dout_valid),
    .dout_ready       (dout_ready),
    .dout             (dout),
    .dout_last        (dout_last),
    .overflow         (overflow),
    .frame_err        (frame_err),
    .dbg_rd_state     (dbg_rd_state),
    .dbg_bank_state   (dbg_bank_state)
  );

  // ---------------- model state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [DW:0]   exp_q[$];            // {last, word}
  logic [DW-1:0] m_mem [2][DEPTH];
  int            m_wr_bank;
  int            m_pix;
  int            m_outstanding;       // closed maps not yet fully read out
  logic          m_ferr;
  logic          m_ovf;
  int            rdy_mode = 0;        // 0 low, 1 high, 2 random 30%

  typedef struct {
    bit         rst_before;
    logic [2:0] ph;
    int         len;
    bit         misplace;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_wr_bank     = 0;
    m_pix         = 0;
    m_outstanding = 0;
    m_ferr        = 1'b0;
    m_ovf         = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst              = 1'b1;
    din_valid        = 1'b0;
    din_last_pix     = 1'b0;
    din_last_in_line = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic write_sample(input logic [2:0] ph, input logic [DW-1:0] d,
                              input bit lil, input bit lp);
    int a;
    @(posedge clk);
    #1;
    chk("buf_full", buf_full, (m_outstanding == 2));
    din_valid        = 1'b1;
    din              = d;
    din_last_in_line = lil;
    din_last_pix     = lp;
    phase            = ph;
    if (m_outstanding < 2) begin
      a = int'(ph) * PIX + m_pix;
      m_mem[m_wr_bank][a] = d;
      if (lil != ((m_pix % 4) == 3)) m_ferr = 1'b1;
      if (lp && (m_pix != PIX - 1)) m_ferr = 1'b1;
      m_pix = lp ? 0 : (m_pix + 1) % PIX;
      if (lp && (ph == 3'd7)) begin
        for (int k = 0; k < DEPTH; k++) exp_q.push_back({(k == DEPTH - 1), m_mem[m_wr_bank][k]});
        m_outstanding++;
        m_wr_bank = 1 - m_wr_bank;
      end
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      din_valid        = 1'b0;
      din_last_pix     = 1'b0;
      din_last_in_line = 1'b0;
    end
  endtask

  task automatic write_channel(input logic [2:0] ph, input int len, input int base,
                               input bit misplace, input bit rnd);
    logic [DW-1:0] d;
    bit lil;
    for (int i = 0; i < len; i++) begin
      d   = rnd ? DW'($urandom) : DW'(base + i);
      lil = ((i % 4) == 3) ^ (misplace && (i == 5));
      write_sample(ph, d, lil, (i == len - 1));
    end
  endtask

  task automatic write_map(input int base, input bit rnd);
    for (int p = 0; p < 8; p++) write_channel(3'(p), PIX, base + p * PIX, 1'b0, rnd);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d words left required=0", exp_q.size());
    end
  endtask

  // ---------------- ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       dout_ready = 1'b0;
      1:       dout_ready = 1'b1;
      default: dout_ready = ($urandom_range(0, 99) < 30);
    endcase
  end

  // ---------------- scoreboard ----------------
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_dout;
  logic          prev_last;
  logic [DW:0]   mon_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", dout_valid, 1);
        chk("stall_dout", dout, prev_dout);
        chk("stall_last", dout_last, prev_last);
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_output actual=%0h required=no word", dout);
        end else begin
          mon_e = exp_q.pop_front();
          chk("dout", dout, mon_e[DW-1:0]);
          chk("dout_last", dout_last, mon_e[DW]);
          if (mon_e[DW]) m_outstanding--;
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
      prev_last  = dout_last;
    end
  end

  // ---------------- test sequence ----------------
  int gaps;

  initial begin
    vecs[0]  = '{1'b0, 3'd0, 16, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 3'd1, 10, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 3'd2, 16, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 3'd3, 16, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 3'd4, 16, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 3'd5, 16, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 3'd6, 16, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 3'd7, 16, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 3'd0, 16, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 3'd5, 16, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'd6, 12, 1'b0, 1'b1};

    rst              = 1'b1;
    din_valid        = 1'b0;
    din              = '0;
    din_last_in_line = 1'b0;
    din_last_pix     = 1'b0;
    phase            = '0;
    dout_ready       = 1'b0;
    model_clear();

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_buf_full", buf_full, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dout_last", dout_last, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_err", frame_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single map, counting data, READY held high, first-word latency
    rdy_mode = 1;
    write_map(0, 1'b0);
    idle(1);
    @(negedge clk);
    chk("lat_n1_valid", dout_valid, 0);
    @(negedge clk);
    chk("lat_n2_valid", dout_valid, 1);
    chk("lat_n2_word0", dout, 0);
    wait_drain(2000);
    chk("map1_frame_err", frame_err, m_ferr);

    // backpressure with random data
    rdy_mode = 2;
    write_map(0, 1'b1);
    idle(1);
    wait_drain(3000);

    // asynchronous reset mid-stream while the next map is being written
    write_map(3000, 1'b1);
    write_channel(3'd0, 8, 0, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    rst       = 1'b1;
    din_valid = 1'b0;
    #1;
    chk("arst_buf_full", buf_full, 0);
    chk("arst_dout_valid", dout_valid, 0);
    chk("arst_dout", dout, 0);
    chk("arst_dout_last", dout_last, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_frame_err", frame_err, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 1;
    write_map(4000, 1'b0);
    idle(1);
    wait_drain(2000);

    // ping-pong: both banks full, dropped write, gap-free release
    rdy_mode = 0;
    write_map(6000, 1'b1);
    write_map(7000, 1'b1);
    write_sample(3'd0, 24'h0abcde, 1'b0, 1'b0);
    idle(1);
    chk("pp_overflow", overflow, m_ovf);
    chk("pp_buf_full_hold", buf_full, (m_outstanding == 2));
    rdy_mode = 1;
    @(posedge clk);
    gaps = 0;
    for (int c = 0; c < 2 * DEPTH; c++) begin
      @(negedge clk);
      if (!(dout_valid && dout_ready)) gaps++;
    end
    chk("pp_gaps", gaps, 0);
    @(posedge clk);
    #1;
    chk("pp_words_left", exp_q.size(), 0);
    write_map(8000, 1'b1);
    idle(1);
    wait_drain(2000);

    // out-of-order phases: PHASE 7 first closes a map holding stale channels
    write_channel(3'd7, PIX, 9000, 1'b0, 1'b0);
    for (int p = 0; p < 8; p++) write_channel(3'(p), PIX, 9500 + p * PIX, 1'b0, 1'b0);
    idle(1);
    wait_drain(2000);
    chk("ooo_frame_err", frame_err, m_ferr);
    chk("ooo_frame_err_clear", frame_err, 0);

    // table: framing errors, pix_cnt restart, sticky clear on reset
    for (int v = 0; v < 11; v++) begin
      if (vecs[v].rst_before) begin
        wait_drain(2000);
        do_reset();
      end
      write_channel(vecs[v].ph, vecs[v].len, 1000 + int'(vecs[v].ph) * PIX, vecs[v].misplace, 1'b0);
      idle(1);
      chk($sformatf("vec%0d_frame_err", v), frame_err, vecs[v].exp_ferr);
    end
    wait_drain(2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
